lfsr_pattern_source: RTL and testbench

Stimulus-side block that drives an LFSR word stream into LFSR_checker with a programmable valid/gap pattern and deliberate error injection. It replaces hand-written valid toggling in benches and on-chip self-test paths, so that lock/unlock behaviour can be exercised from registers. It sits at the transmit end of the LFSR link, feeding i_LFSR/i_valid of the checker side.

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_pattern_source_if.sv | 11 +
 rtl/lfsr_step.sv | 12 +
 rtl/lfsr_pattern_source.sv | 132 +++++++++++++
 tb/tb_lfsr_pattern_source.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR link: x^8+x^6+x^5+x^4+1 tap mask, seed
// value and pattern-source FSM encoding.
package lfsr_pkg;

  // Feedback taps q[7], q[5], q[4], q[3]
  localparam logic [7:0] LFSR_POLY = 8'hB8;
  localparam logic [7:0] LFSR_INIT = 8'hFF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/lfsr_pattern_source_if.sv
// Word stream from the pattern source toward an LFSR checker.
interface lfsr_pattern_source_if #(
  parameter int LFSR_WIDTH = 8
);
  logic [LFSR_WIDTH-1:0] o_LFSR;
  logic                  o_valid;
  logic                  o_err_inj;

  modport master (output o_LFSR, o_valid, o_err_inj);
  modport slave  (input  o_LFSR, o_valid, o_err_inj);
endinterface

// File: rtl/lfsr_step.sv
// One Fibonacci step: shift left, new LSB is the parity of the tapped bits.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int                WIDTH = 8,
  parameter logic [WIDTH-1:0]  POLY  = WIDTH'(LFSR_POLY)
) (
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_q
);
  assign o_q = {i_q[WIDTH-2:0], ^(i_q & POLY)};
endmodule

// File: rtl/lfsr_pattern_source.sv
// LFSR word source with programmable run/gap pattern and periodic
// output-only error injection for exercising an LFSR checker.
module lfsr_pattern_source
  import lfsr_pkg::*;
#(
  parameter int LFSR_WIDTH    = 8,
  parameter int CNT_WIDTH     = 8,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     i_reset,
  input  logic                     i_soft_reset,
  input  logic [LFSR_WIDTH-1:0]    i_seed,
  input  logic                     i_enable,
  input  logic [CNT_WIDTH-1:0]     i_run_len,
  input  logic [CNT_WIDTH-1:0]     i_gap_len,
  input  logic [CNT_WIDTH-1:0]     i_err_period,
  input  logic [LFSR_WIDTH-1:0]    i_err_mask,
  lfsr_pattern_source_if.master    o_stream,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);
  logic [LFSR_WIDTH-1:0]    r_state;
  logic [LFSR_WIDTH-1:0]    r_LFSR;
  logic                     r_valid;
  logic                     r_err_inj;
  logic [1:0]               r_fsm;
  logic [CNT_WIDTH-1:0]     r_run_cnt;
  logic [CNT_WIDTH-1:0]     r_run_len;
  logic [CNT_WIDTH-1:0]     r_gap_cnt;
  logic [CNT_WIDTH-1:0]     r_gap_len;
  logic [CNT_WIDTH-1:0]     r_err_pos;
  logic [CNT_WIDTH-1:0]     r_err_period;
  logic [ERR_CNT_WIDTH-1:0] r_err_count;

  logic [LFSR_WIDTH-1:0] w_state_next;
  logic [LFSR_WIDTH-1:0] w_mask;
  logic [LFSR_WIDTH-1:0] w_seed;
  logic [CNT_WIDTH-1:0]  w_err_period;
  logic [CNT_WIDTH-1:0]  w_err_pos_inc;
  logic                  w_corrupt;
  logic                  w_burst_done;
  logic                  w_gap_done;
  logic                  w_to_gap;
  logic                  w_start;
  logic                  w_emit;
  logic                  w_send;

  lfsr_step #(.WIDTH(LFSR_WIDTH)) u_step (
    .i_q (r_state),
    .o_q (w_state_next)
  );

  assign w_seed       = (i_seed == '0) ? LFSR_WIDTH'(LFSR_INIT) : i_seed;
  assign w_mask       = (i_err_mask == '0) ? LFSR_WIDTH'(1) : i_err_mask;
  assign w_burst_done = (r_run_cnt == r_run_len);
  assign w_gap_done   = (r_gap_cnt == r_gap_len);
  assign w_to_gap     = (r_fsm == ST_RUN) && w_burst_done && (i_gap_len != '0);

  // Error period is re-sampled only when a new error window begins
  assign w_err_period  = (r_err_pos == '0) ? i_err_period : r_err_period;
  assign w_err_pos_inc = r_err_pos + CNT_WIDTH'(1);
  assign w_corrupt     = (w_err_period != '0) && (w_err_pos_inc == w_err_period);

  // w_start opens a new burst (reloading run length); w_emit continues one
  always_comb begin
    w_start = 1'b0;
    w_emit  = 1'b0;
    case (r_fsm)
      ST_IDLE: w_start = (i_run_len != '0);
      ST_RUN: begin
        if (!w_burst_done) w_emit = 1'b1;
        else               w_start = (i_gap_len == '0) && (i_run_len != '0);
      end
      ST_GAP:  w_start = w_gap_done && (i_run_len != '0);
      default: w_start = 1'b0;
    endcase
  end
  assign w_send = w_start || w_emit;

  always_ff @(posedge clk) begin
    if (i_reset || i_soft_reset) begin
      r_state      <= i_reset ? LFSR_WIDTH'(LFSR_INIT) : w_seed;
      r_fsm        <= ST_IDLE;
      r_LFSR       <= '0;
      r_valid      <= 1'b0;
      r_err_inj    <= 1'b0;
      r_run_cnt    <= '0;
      r_run_len    <= '0;
      r_gap_cnt    <= '0;
      r_gap_len    <= '0;
      r_err_pos    <= '0;
      r_err_period <= '0;
      r_err_count  <= '0;
    end else if (!i_enable) begin
      r_fsm     <= ST_IDLE;
      r_valid   <= 1'b0;
      r_err_inj <= 1'b0;
    end else begin
      r_valid   <= w_send;
      r_err_inj <= w_send && w_corrupt;
      if (w_send) begin
        // Corruption touches the output word only; the sequence state advances cleanly
        r_LFSR       <= w_corrupt ? (r_state ^ w_mask) : r_state;
        r_state      <= w_state_next;
        r_err_period <= w_err_period;
        r_err_pos    <= (w_err_period == '0 || w_corrupt) ? '0 : w_err_pos_inc;
        if (w_corrupt && r_err_count != '1) r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
      end
      if (w_start) begin
        r_fsm     <= ST_RUN;
        r_run_cnt <= CNT_WIDTH'(1);
        r_run_len <= i_run_len;
      end else if (w_emit) begin
        r_run_cnt <= r_run_cnt + CNT_WIDTH'(1);
      end else if (w_to_gap) begin
        r_fsm     <= ST_GAP;
        r_gap_cnt <= CNT_WIDTH'(1);
        r_gap_len <= i_gap_len;
      end else if (r_fsm == ST_GAP && !w_gap_done) begin
        r_gap_cnt <= r_gap_cnt + CNT_WIDTH'(1);
      end else begin
        r_fsm <= ST_IDLE;
      end
    end
  end

  assign o_stream.o_LFSR    = r_LFSR;
  assign o_stream.o_valid   = r_valid;
  assign o_stream.o_err_inj = r_err_inj;
  assign o_err_count        = r_err_count;

endmodule

// File: tb/tb_lfsr_pattern_source.sv
// Scoreboard bench: a pattern/sequence reference model queues the expected
// per-cycle output, an independent monitor pops and compares.
module tb_lfsr_pattern_source;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset;
  logic        i_soft_reset;
  logic [7:0]  i_seed;
  logic        i_enable;
  logic [7:0]  i_run_len;
  logic [7:0]  i_gap_len;
  logic [7:0]  i_err_period;
  logic [7:0]  i_err_mask;
  logic [15:0] o_err_count;

  lfsr_pattern_source_if #(.LFSR_WIDTH(8)) stream_if ();

  lfsr_pattern_source #(
    .LFSR_WIDTH    (8),
    .CNT_WIDTH     (8),
    .ERR_CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .i_reset      (i_reset),
    .i_soft_reset (i_soft_reset),
    .i_seed       (i_seed),
    .i_enable     (i_enable),
    .i_run_len    (i_run_len),
    .i_gap_len    (i_gap_len),
    .i_err_period (i_err_period),
    .i_err_mask   (i_err_mask),
    .o_stream     (stream_if.master),
    .o_err_count  (o_err_count)
  );

  typedef struct {
    bit          valid;
    bit          chk_lfsr;
    logic [7:0]  lfsr;
    bit          err_inj;
    int          errs;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] seen_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] ref6 [6] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

  // Reference model: next word to send, position in the run/gap pattern,
  // words sent since (soft) reset, corruptions so far, last output word.
  logic [7:0] m_word;
  logic [7:0] m_last;
  int         m_t;
  bit         m_active;
  int         m_words;
  int         m_errs;

  function automatic logic [7:0] poly_next(input logic [7:0] q);
    int taps;
    taps = int'(q[7]) + int'(q[5]) + int'(q[4]) + int'(q[3]);
    return 8'((int'(q) * 2 + taps % 2) % 256);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predict the output of the coming rising edge from the current inputs,
  // queue it, then advance to the next falling edge.
  task automatic cyc();
    exp_t e;
    int   run, gap, per;
    bit   corrupt;
    e.valid = 0; e.chk_lfsr = 0; e.lfsr = 8'h00; e.err_inj = 0;
    run = int'(i_run_len); gap = int'(i_gap_len); per = int'(i_err_period);
    if (i_reset || i_soft_reset) begin
      m_word   = (i_reset || i_seed == 8'h00) ? 8'hFF : i_seed;
      m_active = 0; m_words = 0; m_errs = 0; m_last = 8'h00;
      e.chk_lfsr = 1;
    end else if (!i_enable) begin
      m_active = 0;
    end else begin
      if (!m_active) begin m_active = 1; m_t = 0; end
      if (run != 0 && (m_t % (run + gap)) < run) begin
        m_words++;
        corrupt   = (per != 0) && (m_words % per == 0);
        e.valid   = 1;
        e.err_inj = corrupt;
        e.lfsr    = corrupt ? (m_word ^ ((i_err_mask == 8'h00) ? 8'h01 : i_err_mask)) : m_word;
        if (corrupt) m_errs++;
        m_word = poly_next(m_word);
        m_last = e.lfsr;
        e.chk_lfsr = 1;
      end else if (run != 0) begin
        e.chk_lfsr = 1;
        e.lfsr     = m_last;
      end
      m_t++;
    end
    e.errs = m_errs;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("o_valid", int'(stream_if.o_valid), int'(e.valid));
        chk("o_err_inj", int'(stream_if.o_err_inj), int'(e.err_inj));
        chk("o_err_count", int'(o_err_count), e.errs);
        if (e.chk_lfsr) chk("o_LFSR", int'(stream_if.o_LFSR), int'(e.lfsr));
        if (stream_if.o_valid) seen_q.push_back(stream_if.o_LFSR);
        $display("cyc t=%0t valid=%0b word=%02h inj=%0b errs=%0d", $time,
                 stream_if.o_valid, stream_if.o_LFSR, stream_if.o_err_inj, o_err_count);
      end
    end
  end

  task automatic check_first6(input string name);
    if (seen_q.size() < 6) begin
      chk({name, "_count"}, seen_q.size(), 6);
    end else begin
      for (int k = 0; k < 6; k++) chk(name, int'(seen_q[k]), int'(ref6[k]));
    end
  endtask

  // Soft reset with a fixed configuration, then n enabled cycles with an
  // optional forced drop window and optional random drops, then one idle cycle.
  task automatic seg(input logic [7:0] seed, input logic [7:0] run, input logic [7:0] gap,
                     input logic [7:0] per, input logic [7:0] mask, input int n,
                     input int drop_at, input int drop_len, input bit rnd_drops);
    i_seed = seed; i_run_len = run; i_gap_len = gap; i_err_period = per; i_err_mask = mask;
    i_enable = 1'b1; i_soft_reset = 1'b1;
    cyc(); cyc();
    i_soft_reset = 1'b0;
    seen_q.delete();
    for (int c = 0; c < n; c++) begin
      i_enable = !((c >= drop_at && c < drop_at + drop_len) ||
                   (rnd_drops && $urandom_range(15) == 0));
      cyc();
    end
    i_enable = 1'b0;
    cyc();
  endtask

  initial begin : stimulus
    i_reset = 1'b1; i_soft_reset = 1'b1; i_seed = 8'h5A; i_enable = 1'b0;
    i_run_len = 8'd4; i_gap_len = 8'd0; i_err_period = 8'd0; i_err_mask = 8'h00;
    m_word = 8'hFF; m_last = 8'h00; m_t = 0; m_active = 0; m_words = 0; m_errs = 0;
    cyc(); cyc(); cyc();
    i_soft_reset = 1'b0;
    cyc();
    // reset beat the seed: sequence starts at all ones
    i_reset = 1'b0; i_enable = 1'b1;
    seen_q.delete();
    repeat (8) cyc();
    i_enable = 1'b0;
    cyc();
    check_first6("reset_wins_seq");

    seg(8'hFF, 8'd4, 8'd0, 8'd0, 8'h00, 12, -1, 0, 0);
    check_first6("seed_ff_seq");
    seg(8'h00, 8'd4, 8'd0, 8'd0, 8'h00, 12, -1, 0, 0);
    check_first6("seed_00_seq");
    seg(8'($urandom_range(255, 1)), 8'd4, 8'd1, 8'd0, 8'h00, 25, -1, 0, 0);
    seg(8'hFF, 8'd8, 8'd0, 8'd5, 8'h00, 50, -1, 0, 0);
    chk("err_count_after_50", int'(o_err_count), 10);
    seg(8'($urandom), 8'd6, 8'd2, 8'd0, 8'h00, 30, 8, 3, 0);
    seg(8'($urandom), 8'd0, 8'd0, 8'd0, 8'h00, 5, -1, 0, 0);

    // reset while running with errors already counted
    seg(8'hFF, 8'd5, 8'd1, 8'd3, 8'h81, 20, -1, 0, 0);
    i_enable = 1'b1;
    repeat (3) cyc();
    i_reset = 1'b1;
    cyc();
    i_reset = 1'b0;
    repeat (10) cyc();
    i_enable = 1'b0;
    cyc();

    for (int s = 0; s < 20; s++) begin
      seg(8'($urandom), 8'($urandom_range(6, 1)), 8'($urandom_range(3, 0)),
          8'($urandom_range(6, 0)), ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom),
          int'($urandom_range(60, 20)), -1, 0, 1);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
